regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU/execute result and requester 1 is the memory load result.
- Each requester has a 1-entry holding register with a valid/ready handshake.
- Arbitration is round-robin; the winning entry drives the regfile write outputs from registers.
- Sits between execute/memory writeback and the regfile write port (reg_write, write_register, write_data).

---
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between two writeback
// requesters: requester 0 is the ALU/execute result and requester 1 is the
// memory load result. Each requester owns a 1-entry holding slot. The winning
// slot drives registered regfile write outputs (reg_write, write_register,
// write_data, grant_id).
//
// Handshake: a slot accepts {reg, data} at a posedge where wbN_valid &&
// wbN_ready. wbN_ready = !occ_N || grant_N, so a slot being granted can be
// refilled at the same edge. The requester must hold valid/reg/data stable
// until it sees ready; ready never depends on valid.
//
// Optional feature macro: REGARB_FIXED_PRIO_EN
//   undefined : round-robin between the two slots when both are occupied
//   defined   : fixed priority, requester 1 (load) always wins on contention;
//               requester 0 can starve while loads keep streaming in
//
// Writes to XZR_IDX consume a grant cycle but leave reg_write low.

module regfile_write_arbiter #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5,
  parameter int XZR_IDX = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  logic [ADDR_W-1:0] wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [ADDR_W-1:0] wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_id,
  output logic              contention
);

  localparam logic [ADDR_W-1:0] XZR = XZR_IDX[ADDR_W-1:0];

  // Holding slots
  logic              occ_0, occ_1;
  logic [ADDR_W-1:0] reg_0, reg_1;
  logic [DATA_W-1:0] data_0, data_1;

  logic              grant_0, grant_1;
  logic              acc_0, acc_1;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

`ifndef REGARB_FIXED_PRIO_EN
  // Round-robin pointer: 0 means requester 0 wins the next contention
  logic rr;
`endif

  // Grant selection from slot occupancy
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (occ_0 && occ_1) begin
`ifdef REGARB_FIXED_PRIO_EN
      grant_1 = 1'b1;
`else
      grant_0 = !rr;
      grant_1 = rr;
`endif
    end else begin
      grant_0 = occ_0;
      grant_1 = occ_1;
    end
  end

  // Ready, accept, contention and the winning entry's payload
  always_comb begin
    wb0_ready  = !occ_0 || grant_0;
    wb1_ready  = !occ_1 || grant_1;
    acc_0      = wb0_valid && wb0_ready;
    acc_1      = wb1_valid && wb1_ready;
    contention = occ_0 && occ_1;
    sel_reg    = grant_1 ? reg_1  : reg_0;
    sel_data   = grant_1 ? data_1 : data_0;
  end

  // Slot 0: load on accept, clear on grant unless refilled at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_0  <= 1'b0;
      reg_0  <= '0;
      data_0 <= '0;
    end else if (acc_0) begin
      occ_0  <= 1'b1;
      reg_0  <= wb0_reg;
      data_0 <= wb0_data;
    end else if (grant_0) begin
      occ_0  <= 1'b0;
    end
  end

  // Slot 1: load on accept, clear on grant unless refilled at the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_1  <= 1'b0;
      reg_1  <= '0;
      data_1 <= '0;
    end else if (acc_1) begin
      occ_1  <= 1'b1;
      reg_1  <= wb1_reg;
      data_1 <= wb1_data;
    end else if (grant_1) begin
      occ_1  <= 1'b0;
    end
  end

`ifndef REGARB_FIXED_PRIO_EN
  // Round-robin pointer moves to the requester that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (grant_0) begin
      rr <= 1'b1;
    end else if (grant_1) begin
      rr <= 1'b0;
    end
  end
`endif

  // Registered regfile write port; index/data/grant_id hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      grant_id       <= 1'b0;
    end else if (grant_0 || grant_1) begin
      reg_write      <= (sel_reg != XZR);
      write_register <= sel_reg;
      write_data     <= sel_data;
      grant_id       <= grant_1;
    end else begin
      reg_write      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter. Stimulus pushes hand-ordered
// expected writes {grant_id, reg, data} into exp_q; an independent monitor
// pops and compares every cycle the DUT asserts reg_write. Point checks cover
// reset, ready/contention timing and the XZR cycle.

module tb_regfile_write_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int EW     = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb0_valid = 1'b0;
  logic              wb0_ready;
  logic [ADDR_W-1:0] wb0_reg = '0;
  logic [DATA_W-1:0] wb0_data = '0;
  logic              wb1_valid = 1'b0;
  logic              wb1_ready;
  logic [ADDR_W-1:0] wb1_reg = '0;
  logic [DATA_W-1:0] wb1_data = '0;
  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              grant_id;
  logic              contention;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .XZR_IDX(31)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .grant_id(grant_id), .contention(contention)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic g, input logic [ADDR_W-1:0] r,
                                        input logic [DATA_W-1:0] d);
    return {g, r, d};
  endfunction

  // Monitor: every committed write must match the head of the expected queue
  always @(posedge clk) begin
    #1;
    if (rst_n && reg_write) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got g=%0d reg=%0d data=0x%0h expected no write",
                 grant_id, write_register, write_data);
      end else begin
        check("wb_commit", {grant_id, write_register, write_data}, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic idle();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Both requesters offer beats back-to-back, each held until accepted
  task automatic stream(input int n0, input int n1,
                        input logic [DATA_W-1:0] base0, input logic [DATA_W-1:0] base1);
    int  i0 = 0;
    int  i1 = 0;
    int  cyc = 0;
    logic a0, a1;
    while ((i0 < n0 || i1 < n1) && cyc < 100) begin
      @(negedge clk);
      wb0_valid = (i0 < n0);
      wb0_reg   = ADDR_W'(i0 + 1);
      wb0_data  = base0 + DATA_W'(i0);
      wb1_valid = (i1 < n1);
      wb1_reg   = ADDR_W'(i1 + 16);
      wb1_data  = base1 + DATA_W'(i1);
      #1;
      a0 = wb0_valid && wb0_ready;
      a1 = wb1_valid && wb1_ready;
      @(posedge clk);
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    @(negedge clk);
    idle();
    check("stream_complete", {i0, i1}, {n0, n1});
  endtask

  int cnt;

  initial begin
    // Reset state
    #1;
    check("rst_reg_write", reg_write, 0);
    check("rst_write_register", write_register, 0);
    check("rst_write_data", write_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_readies", {wb0_ready, wb1_ready}, 2'b11);
    check("rst_contention", contention, 0);
    wait_cycles(2);
    rst_n = 1'b1;

    // Single write from requester 0
    @(negedge clk);
    wb0_valid = 1'b1; wb0_reg = 5'd5; wb0_data = 64'hDEAD;
    exp_q.push_back(ent(1'b0, 5'd5, 64'hDEAD));
    @(negedge clk);
    idle();
    check("single_not_yet", reg_write, 0);
    @(negedge clk);
    check("single_out", {reg_write, write_register, write_data, grant_id},
          {1'b1, 5'd5, 64'hDEAD, 1'b0});
    @(negedge clk);
    check("single_we_drop", reg_write, 0);

    // Contention from reset: reg 3 then reg 4 on consecutive cycles
    do_reset();
    @(negedge clk);
    wb0_valid = 1'b1; wb0_reg = 5'd3; wb0_data = 64'h11;
    wb1_valid = 1'b1; wb1_reg = 5'd4; wb1_data = 64'h22;
    exp_q.push_back(ent(1'b0, 5'd3, 64'h11));
    exp_q.push_back(ent(1'b1, 5'd4, 64'h22));
    @(negedge clk);
    idle();
    check("cont_flag", contention, 1);
    check("cont_ready0", wb0_ready, 1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (!wb1_ready) cnt++;
      if (i == 1) check("cont_first", {reg_write, write_register, grant_id}, {1'b1, 5'd3, 1'b0});
      if (i == 2) check("cont_second", {reg_write, write_register, grant_id}, {1'b1, 5'd4, 1'b1});
      if (i == 2) check("cont_flag_clear", contention, 0);
      @(negedge clk);
    end
    check("cont_ready1_low_cycles", cnt, 1);

`ifdef REGARB_FIXED_PRIO_EN
    // Fixed priority: loads win every contention, wb0 waits until wb1 drops
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(1'b1, ADDR_W'(k + 16), 64'h200 + DATA_W'(k)));
    exp_q.push_back(ent(1'b0, 5'd1, 64'h100));
    stream(1, 4, 64'h100, 64'h200);
`else
    // Round-robin streaming: grants alternate 0,1,0,1 with no lost beat
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(ent(1'b0, ADDR_W'(k + 1),  64'h100 + DATA_W'(k)));
      exp_q.push_back(ent(1'b1, ADDR_W'(k + 16), 64'h200 + DATA_W'(k)));
    end
    stream(4, 4, 64'h100, 64'h200);
`endif
    wait_cycles(4);
    check("stream_drained", exp_q.size(), 0);

    // XZR write consumes a grant but does not commit; next write commits
    do_reset();
    @(negedge clk);
    wb1_valid = 1'b1; wb1_reg = 5'd31; wb1_data = 64'hFF;
    @(negedge clk);
    wb1_reg = 5'd2; wb1_data = 64'h33;
    exp_q.push_back(ent(1'b1, 5'd2, 64'h33));
    @(negedge clk);
    idle();
    check("xzr_cycle", {reg_write, write_register, write_data, grant_id},
          {1'b0, 5'd31, 64'hFF, 1'b1});
    @(negedge clk);
    check("xzr_next_commit", {reg_write, write_register, write_data, grant_id},
          {1'b1, 5'd2, 64'h33, 1'b1});

    // Reset mid-stream with an output pending and slot 1 still full
    do_reset();
    @(negedge clk);
    wb0_valid = 1'b1; wb0_reg = 5'd6; wb0_data = 64'h66;
    wb1_valid = 1'b1; wb1_reg = 5'd7; wb1_data = 64'h77;
    exp_q.push_back(ent(1'b0, 5'd6, 64'h66));
    @(negedge clk);
    idle();
    check("midrst_contention", contention, 1);
    @(negedge clk);
    check("midrst_pre_out", {reg_write, write_register}, {1'b1, 5'd6});
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {reg_write, write_register, write_data, grant_id}, '0);
    check("midrst_readies", {wb0_ready, wb1_ready, contention}, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reg_write) cnt++;
    end
    check("midrst_no_pulse", cnt, 0);
    check("midrst_ready_after", {wb0_ready, wb1_ready}, 2'b11);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
